// File: rtl/ct_rtu_encode_pipe.sv
// One-hot/multi-hot to binary encoder with a single registered output stage,
// valid/ready handshake, selectable OR/priority encoding and error tracking.
module ct_rtu_encode_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned ENC_W = 6,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             x_in_vld,
  input  logic [WIDTH-1:0] x_in_expand,
  output logic             x_in_rdy,
  output logic             x_out_vld,
  output logic [ENC_W-1:0] x_out_num,
  output logic             x_out_err,
  input  logic             x_out_rdy,
  input  logic             x_err_clr,
  output logic             x_err_sticky,
  output logic [CNT_W-1:0] x_err_cnt
);

  logic             out_vld_q, out_vld_d;
  logic [ENC_W-1:0] out_num_q, out_num_d;
  logic             out_err_q, out_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             accept;
  logic             in_err;
  logic             pri_found;
  logic [ENC_W-1:0] or_num, pri_num, enc_num;

  assign x_in_rdy = ~out_vld_q | x_out_rdy;
  assign accept   = x_in_vld & x_in_rdy;

  always_comb begin
    or_num    = '0;
    pri_num   = '0;
    pri_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (x_in_expand[i]) begin
        or_num = or_num | ENC_W'(i);
        if (!pri_found) begin
          pri_num   = ENC_W'(i);
          pri_found = 1'b1;
        end
      end
    end
  end

  // x & (x-1) is non-zero exactly when more than one bit is set.
  assign in_err  = (x_in_expand == '0) |
                   ((x_in_expand & (x_in_expand - WIDTH'(1))) != '0);
  assign enc_num = (MODE == 1) ? pri_num : or_num;

  always_comb begin
    out_vld_d    = out_vld_q;
    out_num_d    = out_num_q;
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (accept) begin
      out_vld_d = 1'b1;
      out_num_d = enc_num;
      out_err_d = in_err;
    end else if (x_out_rdy) begin
      out_vld_d = 1'b0;
    end
    // A fresh error outranks a simultaneous clear: restart the count at one.
    if (accept && in_err) begin
      err_sticky_d = 1'b1;
      if (x_err_clr)
        err_cnt_d = CNT_W'(1);
      else if (!(&err_cnt_q))
        err_cnt_d = err_cnt_q + CNT_W'(1);
    end else if (x_err_clr) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      out_vld_q    <= 1'b0;
      out_num_q    <= '0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_num_q    <= out_num_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign x_out_vld    = out_vld_q;
  assign x_out_num    = out_num_q;
  assign x_out_err    = out_err_q;
  assign x_err_sticky = err_sticky_q;
  assign x_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ct_rtu_encode_pipe.sv
// Directed bench: three encoder instances (OR mode, priority mode, 2-bit
// counter) share one stimulus stream; each task checks its own scenario.
module tb_ct_rtu_encode_pipe;

  logic        clk;
  logic        rst_b;
  logic        in_vld;
  logic [63:0] in_x;
  logic        out_rdy;
  logic        err_clr;

  logic       rdy0, vld0, err0, stk0;
  logic [5:0] num0;
  logic [7:0] cnt0;
  logic       rdy1, vld1, err1, stk1;
  logic [5:0] num1;
  logic [7:0] cnt1;
  logic       rdy2, vld2, err2, stk2;
  logic [5:0] num2;
  logic [1:0] cnt2;

  int vectors;
  int miscompares;

  ct_rtu_encode_pipe #(.WIDTH(64), .ENC_W(6), .MODE(0), .CNT_W(8)) dut0 (
    .forever_cpuclk(clk), .cpurst_b(rst_b), .x_in_vld(in_vld),
    .x_in_expand(in_x), .x_in_rdy(rdy0), .x_out_vld(vld0), .x_out_num(num0),
    .x_out_err(err0), .x_out_rdy(out_rdy), .x_err_clr(err_clr),
    .x_err_sticky(stk0), .x_err_cnt(cnt0));

  ct_rtu_encode_pipe #(.WIDTH(64), .ENC_W(6), .MODE(1), .CNT_W(8)) dut1 (
    .forever_cpuclk(clk), .cpurst_b(rst_b), .x_in_vld(in_vld),
    .x_in_expand(in_x), .x_in_rdy(rdy1), .x_out_vld(vld1), .x_out_num(num1),
    .x_out_err(err1), .x_out_rdy(out_rdy), .x_err_clr(err_clr),
    .x_err_sticky(stk1), .x_err_cnt(cnt1));

  ct_rtu_encode_pipe #(.WIDTH(64), .ENC_W(6), .MODE(0), .CNT_W(2)) dut2 (
    .forever_cpuclk(clk), .cpurst_b(rst_b), .x_in_vld(in_vld),
    .x_in_expand(in_x), .x_in_rdy(rdy2), .x_out_vld(vld2), .x_out_num(num2),
    .x_out_err(err2), .x_out_rdy(out_rdy), .x_err_clr(err_clr),
    .x_err_sticky(stk2), .x_err_cnt(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_b = 1'b0; in_vld = 1'b0; in_x = '0; out_rdy = 1'b1; err_clr = 1'b0;
    #12;
    vectors++;
    if ({vld0, num0, err0, stk0, cnt0} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_dut0 got %h want 0", {vld0, num0, err0, stk0, cnt0});
    end
    vectors++;
    if ({vld2, num2, err2, stk2, cnt2} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_dut2 got %h want 0", {vld2, num2, err2, stk2, cnt2});
    end
    vectors++;
    if (rdy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_rdy got %b want 1", rdy0);
    end
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_sweep();
    out_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_vld = 1'b1;
      in_x   = 64'd1 << i;
      step();
      vectors++;
      if ({vld0, num0, err0} !== {1'b1, 6'(i), 1'b0}) begin
        miscompares++;
        $display("FAIL sweep_mode0 i=%0d got vld=%b num=%0d err=%b want 1/%0d/0",
                 i, vld0, num0, err0, i);
      end
      vectors++;
      if ({vld1, num1, err1} !== {1'b1, 6'(i), 1'b0}) begin
        miscompares++;
        $display("FAIL sweep_mode1 i=%0d got vld=%b num=%0d err=%b want 1/%0d/0",
                 i, vld1, num1, err1, i);
      end
      vectors++;
      if (cnt0 !== 8'd0 || stk0 !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_cnt i=%0d got cnt=%0d stk=%b want 0/0", i, cnt0, stk0);
      end
    end
    in_vld = 1'b0;
    step();
    vectors++;
    if (vld0 !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_drain got vld=%b want 0", vld0);
    end
  endtask

  task automatic test_multihot();
    in_vld = 1'b1;
    in_x   = 64'h0000_0000_0000_0014;
    step();
    in_vld = 1'b0;
    vectors++;
    if ({num0, err0, stk0, cnt0} !== {6'd6, 1'b1, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL multihot_mode0 got num=%0d err=%b stk=%b cnt=%0d want 6/1/1/1",
               num0, err0, stk0, cnt0);
    end
    vectors++;
    if ({num1, err1, stk1, cnt1} !== {6'd2, 1'b1, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL multihot_mode1 got num=%0d err=%b stk=%b cnt=%0d want 2/1/1/1",
               num1, err1, stk1, cnt1);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_x    = 64'd1 << 5;
    step();
    vectors++;
    if ({vld0, num0} !== {1'b1, 6'd5}) begin
      miscompares++;
      $display("FAIL bp_first got vld=%b num=%0d want 1/5", vld0, num0);
    end
    out_rdy = 1'b0;
    in_x    = 64'd1 << 9;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({rdy0, vld0, num0} !== {1'b0, 1'b1, 6'd5}) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d got rdy=%b vld=%b num=%0d want 0/1/5",
                 c, rdy0, vld0, num0);
      end
      step();
    end
    out_rdy = 1'b1;
    #1;
    vectors++;
    if (rdy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_rdy got %b want 1", rdy0);
    end
    step();
    in_vld = 1'b0;
    vectors++;
    if ({vld0, num0} !== {1'b1, 6'd9}) begin
      miscompares++;
      $display("FAIL bp_second got vld=%b num=%0d want 1/9", vld0, num0);
    end
    step();
    vectors++;
    if (vld0 !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_dup got vld=%b want 0", vld0);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    pulse_reset();
    out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_vld = 1'b1;
      in_x   = '0;
      step();
      vectors++;
      if ({cnt2, num2, err2, stk2} !== {exp_cnt[k], 6'd0, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL sat k=%0d got cnt=%0d num=%0d err=%b stk=%b want %0d/0/1/1",
                 k, cnt2, num2, err2, stk2, exp_cnt[k]);
      end
      vectors++;
      if (cnt0 !== 8'(k + 1)) begin
        miscompares++;
        $display("FAIL sat_wide k=%0d got cnt=%0d want %0d", k, cnt0, k + 1);
      end
    end
    in_vld = 1'b0;
    step();
  endtask

  task automatic test_clear_collision();
    pulse_reset();
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_x    = 64'h3;
    step();
    step();
    vectors++;
    if (cnt0 !== 8'd2) begin
      miscompares++;
      $display("FAIL clr_setup got cnt=%0d want 2", cnt0);
    end
    in_x    = '0;
    err_clr = 1'b1;
    step();
    vectors++;
    if ({cnt0, stk0} !== {8'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL clr_collide got cnt=%0d stk=%b want 1/1", cnt0, stk0);
    end
    in_vld = 1'b0;
    step();
    err_clr = 1'b0;
    vectors++;
    if ({cnt0, stk0} !== {8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL clr_alone got cnt=%0d stk=%b want 0/0", cnt0, stk0);
    end
  endtask

  task automatic test_ignored();
    in_vld = 1'b0;
    in_x   = '0;
    step();
    in_x = 64'hF0;
    step();
    vectors++;
    if ({vld0, stk0, cnt0} !== {1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL ignored got vld=%b stk=%b cnt=%0d want 0/0/0", vld0, stk0, cnt0);
    end
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_x    = 64'd0;
    step();
    in_x    = 64'd1 << 7;
    step();
    out_rdy = 1'b0;
    in_vld  = 1'b0;
    step();
    vectors++;
    if ({vld0, num0, stk0} !== {1'b1, 6'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_pre got vld=%b num=%0d stk=%b want 1/7/1", vld0, num0, stk0);
    end
    rst_b = 1'b0;
    #1;
    vectors++;
    if ({vld0, num0, err0, stk0, cnt0} !== 17'd0) begin
      miscompares++;
      $display("FAIL rstmid_async got %h want 0", {vld0, num0, err0, stk0, cnt0});
    end
    rst_b = 1'b1;
    #1;
    vectors++;
    if (rdy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_rdy got %b want 1", rdy0);
    end
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_x    = 64'd1 << 12;
    step();
    in_vld = 1'b0;
    vectors++;
    if ({vld0, num0, err0} !== {1'b1, 6'd12, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_first got vld=%b num=%0d err=%b want 1/12/0", vld0, num0, err0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sweep();
    test_multihot();
    test_backpressure();
    test_saturation();
    test_clear_collision();
    test_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
